uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UARTTransmitter between N byte-stream requesters (board dump, ANSI home/CRLF, banner ROM, ...).
//  A requester holds a locked grant for a whole packet, from the first byte to the byte flagged last.
//  Packets never interleave on the wire.
//  Round-robin grant between packets; a lock watchdog frees the UART if a granted requester stalls.
//  Sits between the game/control FSMs and uart_tx_inst.valid/in/ready.
// PARAMETERS
//  N_REQ         4     number of requesters (2..8)
//  ID_W          2     grant id width, = clog2(N_REQ)
//  LOCK_TIMEOUT  4096  cycles a granted requester may leave req_valid low in LOAD before its grant is revoked
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          asynchronous active-low reset
//  enable       in   1          0: finish current packet, issue no new grants
//  req_valid    in   N_REQ      requester i has a byte
//  req_data     in   8*N_REQ    byte of requester i at [8i+7:8i]
//  req_last     in   N_REQ      byte is last of the packet
//  req_ready    out  N_REQ      byte of requester i consumed this cycle
//  tx_valid     out  1          to UARTTransmitter.valid
//  tx_data      out  8          to UARTTransmitter.in
//  tx_ready     in   1          from UARTTransmitter.ready
//  grant_id     out  ID_W       current/last granted requester
//  busy         out  1          state != IDLE
//  timeout_err  out  1          1-cycle pulse when a lock is revoked
// BEHAVIOUR
//  Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Every flop clears immediately on rst_n=0.
//  Reset values: tx_valid=0, tx_data=0, req_ready=0, grant_id=0, busy=0, timeout_err=0, rr_ptr=0, state=IDLE.
//  Reset during a transfer drops tx_valid at once. The partial packet is abandoned; no recovery byte is sent.
//  Requester handshake: a byte transfers when req_valid[i] & req_ready[i].
//  req_ready is combinational: (state==LOAD) & (i==grant_id) & req_valid[i].
//  UART handshake (matches the transmitter):
//  - tx_valid rises only while tx_ready=1.
//  - tx_valid and tx_data are held until tx_ready falls (acceptance), then tx_valid is cleared.
//  FSM:
//  - IDLE: if enable & |req_valid, then grant_id <= first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N_REQ; go to LOAD.
//  - LOAD: on handshake, capture data/last into hold regs, clear wd, go to ISSUE.
//    Otherwise wd++. When wd==LOCK_TIMEOUT-1: pulse timeout_err, rr_ptr <= grant_id+1, go to IDLE.
//  - ISSUE: if tx_ready, then tx_valid <= 1, tx_data <= hold, go to WAIT_ACK.
//  - WAIT_ACK: if !tx_ready, then tx_valid <= 0.
//    If last_q: rr_ptr <= grant_id+1 (wraps N_REQ-1 -> 0), go to IDLE. Otherwise go to LOAD.
//  Latency:
//  - req_valid to grant: 1 cycle.
//  - grant to req_ready: same cycle in LOAD.
//  - accepted byte to tx_valid: 1 cycle when tx_ready=1.
//  Minimum 4 cycles per byte; in practice limited by the baud rate.
//  Boundaries:
//  - A single-byte packet (last on the first byte) is legal.
//  - Requests arriving mid-packet wait; no preemption.
//  - The same requester re-requesting right after its own packet loses to any other pending requester.
//  - enable falling mid-packet has no effect until IDLE.
//  - wd is 13 bits and saturates; it counts only in LOAD.
//  - req_last on a non-granted port is ignored.
// STRUCTURE
//  uart_arb_defs.vh: FSM state localparams (IDLE=0, LOAD=1, ISSUE=2, WAIT_ACK=3) and the ASCII constants CR=13, LF=10, ESC=27.
//  Sub-module rr_picker #(N_REQ): purely combinational rotating-priority search.
//  - inputs: req vector, base pointer
//  - outputs: any, index
//  Everything else (FSM, hold regs, watchdog, rr_ptr) lives in this module.
// TESTING
//  Bench uses a behavioural transmitter: ready falls 1 cycle after valid and rises 20 cycles later.
//  1. Req0 sends the 4-byte packet 1B 5B 3B 48, last on 48.
//     -> tx_data sequence 1B,5B,3B,48; exactly 4 req_ready[0] pulses; busy=0 after; rr_ptr=1.
//  2. Req0 and req2 both assert at once, each with 2 bytes, rr_ptr=0.
//     -> req0's 2 bytes first, then req2's 2 bytes; no interleave; grant_id 0 then 2.
//  3. Req3 finishes a packet; then req3 and req0 both request.
//     -> req0 granted (pointer wrapped 3 -> 0).
//  4. Req1 granted, sends 1 byte without last, then drops req_valid, LOCK_TIMEOUT=16.
//     -> timeout_err pulses exactly 16 cycles after entering LOAD; return to IDLE; req2 pending is granted next.
//  5. rst_n pulled low while tx_valid=1.
//     -> tx_valid=0 in the same cycle without a clock edge; after release, no byte is issued without a new request.
//  6. enable=0 while req1 is mid-packet and req2 is waiting.
//     -> req1 completes all bytes; req2 gets no grant until enable=1.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared FSM encoding, watchdog width and ASCII control bytes for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    ISSUE    = 2'd2,
    WAIT_ACK = 2'd3
  } arb_state_e;

  localparam int WD_W = 13;

  localparam logic [7:0] ASCII_CR  = 8'd13;
  localparam logic [7:0] ASCII_LF  = 8'd10;
  localparam logic [7:0] ASCII_ESC = 8'd27;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational rotating-priority search: the first asserted request at or after base_i,
// wrapping modulo N_REQ.
module uart_tx_arbiter_rr_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  base_i,
  output logic             any_o,
  output logic [ID_W-1:0]  idx_o
);
  localparam int SW = ID_W + 1;

  logic [SW-1:0]    pos_sum [N_REQ];
  logic [ID_W-1:0]  pos     [N_REQ];
  logic [N_REQ-1:0] rot;

  // rot[k] is the request sitting k places after the base pointer.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    assign pos_sum[gi] = {1'b0, base_i} + SW'(gi);
    assign pos[gi]     = (pos_sum[gi] >= SW'(N_REQ)) ? ID_W'(pos_sum[gi] - SW'(N_REQ))
                                                     : pos_sum[gi][ID_W-1:0];
    assign rot[gi]     = req_i[pos[gi]];
  end

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any_o = 1'b1;
        idx_o = pos[k];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte-stream requesters.
// A grant is locked for a whole packet; a watchdog revokes it if the owner stalls in LOAD.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int ID_W         = $clog2(N_REQ),
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic               tx_valid_o,
  output logic [7:0]         tx_data_o,
  input  logic               tx_ready_i,
  output logic [ID_W-1:0]    grant_id_o,
  output logic               busy_o,
  output logic               timeout_err_o
);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(LOCK_TIMEOUT - 1);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [7:0]      hold_data_q, hold_data_d;
  logic            hold_last_q, hold_last_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            timeout_q, timeout_d;

  logic            pick_any;
  logic [ID_W-1:0] pick_idx;
  logic            handshake;
  logic [7:0]      sel_data;
  logic            sel_last;
  logic [ID_W-1:0] next_ptr;

  uart_tx_arbiter_rr_picker #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_picker (
    .req_i (req_valid_i),
    .base_i(rr_ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign req_ready_o[gi] = (state_q == LOAD) && (grant_id_q == ID_W'(gi)) && req_valid_i[gi];
  end

  assign handshake = |req_ready_o;
  assign sel_data  = req_data_i[{grant_id_q, 3'b000} +: 8];
  assign sel_last  = req_last_i[grant_id_q];
  // The port just served drops to lowest priority for the next decision.
  assign next_ptr  = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    wd_d        = wd_q;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (enable_i && pick_any) begin
          grant_id_d = pick_idx;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (handshake) begin
          hold_data_d = sel_data;
          hold_last_d = sel_last;
          wd_d        = '0;
          state_d     = ISSUE;
        end else if (wd_q == WD_LIMIT) begin
          timeout_d = 1'b1;
          rr_ptr_d  = next_ptr;
          wd_d      = '0;
          state_d   = IDLE;
        end else if (wd_q != '1) begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ISSUE: begin
        if (tx_ready_i) begin
          tx_valid_d = 1'b1;
          tx_data_d  = hold_data_q;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // The transmitter drops ready when it takes the byte.
        if (!tx_ready_i) begin
          tx_valid_d = 1'b0;
          if (hold_last_q) begin
            rr_ptr_d = next_ptr;
            state_d  = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      wd_q        <= '0;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      wd_q        <= wd_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      timeout_q   <= timeout_d;
    end
  end

  assign tx_valid_o    = tx_valid_q;
  assign tx_data_o     = tx_data_q;
  assign grant_id_o    = grant_id_q;
  assign busy_o        = (state_q != IDLE);
  assign timeout_err_o = timeout_q;

endmodule
